// File: rtl/occ_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared constants, state encoding and address helpers for the
//                operand-fetch stage (Occ / C index memory map).
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] C_BASE = 12'hFFC;

    localparam logic [1:0] SYM_A = 2'd0;
    localparam logic [1:0] SYM_C = 2'd1;
    localparam logic [1:0] SYM_G = 2'd2;
    localparam logic [1:0] SYM_T = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_RD2  = 3'd2,
        ST_RDC  = 3'd3,
        ST_LAST = 3'd4,
        ST_OUT  = 3'd5
    } state_t;

    // Occ(s, n) lives in the low 1K words, one 256-entry row per symbol.
    function automatic logic [ADDR_W-1:0] occ_addr(input logic [1:0] sym,
                                                   input logic [DATA_W-1:0] n);
        return {2'b00, sym, n};
    endfunction

    // C(s) occupies the top four words of the address space.
    function automatic logic [ADDR_W-1:0] c_addr(input logic [1:0] sym);
        return C_BASE + {{(ADDR_W-2){1'b0}}, sym};
    endfunction

endpackage
`default_nettype wire

// File: rtl/occ_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : occ_fetch_if
//  Description : Request, index-memory and operand-bundle signals of the
//                operand-fetch stage. master = fetch stage, slave = its
//                environment (request source, memory and ex consumer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface occ_fetch_if;
    import acc_pkg::*;

    // request side
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_position;
    logic [DATA_W-1:0] req_i;
    logic [DATA_W-1:0] req_z;
    logic [DATA_W-1:0] req_k;
    logic [DATA_W-1:0] req_l;
    logic [DATA_W-1:0] req_d_i;
    logic [1:0]        req_read_i;

    // index memory
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // operand bundle toward ex
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        position_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] i_out;
    logic [DATA_W-1:0] z_out;
    logic [DATA_W-1:0] k_out;
    logic [DATA_W-1:0] l_out;
    logic [DATA_W-1:0] d_i_out;
    logic [1:0]        read_i_out;
    logic [DATA_W-1:0] data_1_out;
    logic [DATA_W-1:0] data_2_out;
    logic [DATA_W-1:0] C_out;

    modport master (
        input  req_valid, req_position, req_i, req_z, req_k, req_l, req_d_i, req_read_i,
        output req_ready,
        output mem_en, mem_addr,
        input  mem_rdata,
        input  out_ready,
        output out_valid, position_out, addr_out, i_out, z_out, k_out, l_out,
               d_i_out, read_i_out, data_1_out, data_2_out, C_out
    );

    modport slave (
        output req_valid, req_position, req_i, req_z, req_k, req_l, req_d_i, req_read_i,
        input  req_ready,
        input  mem_en, mem_addr,
        output mem_rdata,
        output out_ready,
        input  out_valid, position_out, addr_out, i_out, z_out, k_out, l_out,
               d_i_out, read_i_out, data_1_out, data_2_out, C_out
    );

endinterface
`default_nettype wire

// File: rtl/occ_fetch_c_cache.sv
`default_nettype none
// ============================================================================
//  Module      : c_cache
//  Description : Four-entry C(s) cache, one register and valid bit per base
//                symbol. Entries are filled on a miss and cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module c_cache
    import acc_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              wr_en,
    input  wire logic [1:0]        wr_sym,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic [1:0]        rd_sym,
    output logic                   hit,
    output logic [DATA_W-1:0]      rd_data
);

    logic [3:0]        r_valid;
    logic [DATA_W-1:0] r_data [4];

    // Fill the entry for the written symbol; reset invalidates everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int n = 0; n < 4; n++) begin
                r_data[n] <= '0;
            end
        end else if (wr_en) begin
            r_valid[wr_sym] <= 1'b1;
            r_data[wr_sym]  <= wr_data;
        end
    end

    assign hit     = r_valid[rd_sym];
    assign rd_data = r_data[rd_sym];

endmodule
`default_nettype wire

// File: rtl/occ_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : occ_fetch
//  Description : Operand-fetch stage feeding ex. Reads Occ(s,k-1), Occ(s,l)
//                and C(s) from the index memory for one backward-search step
//                and presents the operand bundle over valid/ready.
//                Optional macro OCC_FETCH_C_CACHE_EN adds a 4-entry C cache
//                that skips the C read on a hit.
//  Revision    : 1.0 - initial release
// ============================================================================
module occ_fetch
    import acc_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    occ_fetch_if.master bus
);

    state_t            r_state;
    logic              r_req_ready;
    logic              r_out_valid;
    logic              r_mem_en;
    logic [ADDR_W-1:0] r_mem_addr;

    logic [4:0]        r_pos;
    logic [DATA_W-1:0] r_i;
    logic [DATA_W-1:0] r_z;
    logic [DATA_W-1:0] r_k;
    logic [DATA_W-1:0] r_l;
    logic [DATA_W-1:0] r_d_i;
    logic [1:0]        r_s;
    logic              r_k_nz;
    logic              r_c_hit;
    logic [DATA_W-1:0] r_data_1;
    logic [DATA_W-1:0] r_data_2;
    logic [DATA_W-1:0] r_c;

    logic              w_c_hit;
    logic [DATA_W-1:0] w_c_data;

`ifdef OCC_FETCH_C_CACHE_EN
    logic              w_c_wr;

    // Only a miss reaches LAST with C on the read-data bus.
    assign w_c_wr = (r_state == ST_LAST) && !r_c_hit;

    c_cache u_c_cache (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_c_wr),
        .wr_sym  (r_s),
        .wr_data (bus.mem_rdata),
        .rd_sym  (r_s),
        .hit     (w_c_hit),
        .rd_data (w_c_data)
    );
`else
    assign w_c_hit  = 1'b0;
    assign w_c_data = '0;
`endif

    // Fetch sequencer: issues reads one cycle ahead and captures the data
    // returned for the previous issue; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_pos       <= '0;
            r_i         <= '0;
            r_z         <= '0;
            r_k         <= '0;
            r_l         <= '0;
            r_d_i       <= '0;
            r_s         <= '0;
            r_k_nz      <= 1'b0;
            r_c_hit     <= 1'b0;
            r_data_1    <= '0;
            r_data_2    <= '0;
            r_c         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_pos       <= bus.req_position;
                        r_i         <= bus.req_i;
                        r_z         <= bus.req_z;
                        r_k         <= bus.req_k;
                        r_l         <= bus.req_l;
                        r_d_i       <= bus.req_d_i;
                        r_s         <= bus.req_read_i;
                        r_k_nz      <= (bus.req_k != '0);
                        r_c_hit     <= 1'b0;
                        // Occ(s,-1) is zero by definition; no read for it.
                        r_data_1    <= '0;
                        r_req_ready <= 1'b0;
                        r_mem_en    <= 1'b1;
                        if (bus.req_k != '0) begin
                            r_mem_addr <= occ_addr(bus.req_read_i, bus.req_k - 8'd1);
                            r_state    <= ST_RD1;
                        end else begin
                            r_mem_addr <= occ_addr(bus.req_read_i, bus.req_l);
                            r_state    <= ST_RD2;
                        end
                    end
                end
                ST_RD1: begin
                    r_mem_addr <= occ_addr(r_s, r_l);
                    r_state    <= ST_RD2;
                end
                ST_RD2: begin
                    if (r_k_nz) begin
                        r_data_1 <= bus.mem_rdata;
                    end
                    if (w_c_hit) begin
                        r_c_hit    <= 1'b1;
                        r_mem_en   <= 1'b0;
                        r_mem_addr <= '0;
                        r_state    <= ST_LAST;
                    end else begin
                        r_mem_addr <= c_addr(r_s);
                        r_state    <= ST_RDC;
                    end
                end
                ST_RDC: begin
                    r_data_2   <= bus.mem_rdata;
                    r_mem_en   <= 1'b0;
                    r_mem_addr <= '0;
                    r_state    <= ST_LAST;
                end
                ST_LAST: begin
                    if (r_c_hit) begin
                        r_data_2 <= bus.mem_rdata;
                        r_c      <= w_c_data;
                    end else begin
                        r_c      <= bus.mem_rdata;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_mem_en    <= 1'b0;
                    r_mem_addr  <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.mem_en       = r_mem_en;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.out_valid    = r_out_valid;
    assign bus.position_out = r_pos;
    assign bus.addr_out     = occ_addr(r_s, r_l);
    assign bus.i_out        = r_i;
    assign bus.z_out        = r_z;
    assign bus.k_out        = r_k;
    assign bus.l_out        = r_l;
    assign bus.d_i_out      = r_d_i;
    assign bus.read_i_out   = r_s;
    assign bus.data_1_out   = r_data_1;
    assign bus.data_2_out   = r_data_2;
    assign bus.C_out        = r_c;

endmodule
`default_nettype wire

// File: tb/tb_occ_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_occ_fetch
//  Description : Self-checking bench for occ_fetch: directed vector table,
//                reset-in-flight sequence and randomized requests checked
//                against a behavioural model of reads, bundle and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_occ_fetch;
    import acc_pkg::*;

`ifdef OCC_FETCH_C_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    occ_fetch_if bus ();

    occ_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] mem_xor = 8'h00;
    bit         cvalid [4];
    logic [7:0] cval   [4];

    // Synchronous-read memory: contents are the low address byte XOR a key.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_en ? (bus.mem_addr[7:0] ^ mem_xor) : 8'h00;
    end

    function automatic logic [7:0] mem_f(input logic [11:0] a);
        return a[7:0] ^ mem_xor;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bundle(input logic [4:0] pos, input logic [7:0] i, z, k, l, d,
                                input logic [1:0] s, input logic [7:0] d1, d2, c);
        check("out_valid",    bus.out_valid,    1);
        check("position_out", bus.position_out, pos);
        check("addr_out",     bus.addr_out,     {2'b00, s, l});
        check("i_out",        bus.i_out,        i);
        check("z_out",        bus.z_out,        z);
        check("k_out",        bus.k_out,        k);
        check("l_out",        bus.l_out,        l);
        check("d_i_out",      bus.d_i_out,      d);
        check("read_i_out",   bus.read_i_out,   s);
        check("data_1_out",   bus.data_1_out,   d1);
        check("data_2_out",   bus.data_2_out,   d2);
        check("C_out",        bus.C_out,        c);
    endtask

    // One full request: model, drive, observe reads/latency, hold, handshake.
    task automatic run_req(input logic [4:0] pos, input logic [7:0] i, z, k, l, d,
                           input logic [1:0] s, input bit use_tbl,
                           input logic [7:0] t_d1, t_d2, t_c, input int t_lat,
                           input int hold, input logic early);
        logic [11:0] exp_rd[$];
        logic [11:0] got_rd[$];
        bit          hit;
        logic [7:0]  e_d1, e_d2, e_c;
        int          e_lat, j;

        if (k != 8'h00) exp_rd.push_back({2'b00, s, k - 8'd1});
        exp_rd.push_back({2'b00, s, l});
        hit = CACHE && cvalid[s];
        if (!hit) exp_rd.push_back(12'hFFC + {10'd0, s});
        e_d1  = (k != 8'h00) ? mem_f({2'b00, s, k - 8'd1}) : 8'h00;
        e_d2  = mem_f({2'b00, s, l});
        e_c   = hit ? cval[s] : mem_f(12'hFFC + {10'd0, s});
        e_lat = ((k != 8'h00) ? 4 : 3) - (hit ? 1 : 0);
        if (CACHE && !hit) begin
            cvalid[s] = 1'b1;
            cval[s]   = e_c;
        end
        if (use_tbl) begin
            e_d1  = t_d1;
            e_d2  = t_d2;
            e_c   = t_c;
            e_lat = t_lat - (hit ? 1 : 0);
        end

        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_position = pos;
        bus.req_i        = i;
        bus.req_z        = z;
        bus.req_k        = k;
        bus.req_l        = l;
        bus.req_d_i      = d;
        bus.req_read_i   = s;
        bus.out_ready    = early;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_position = 5'($urandom);
        bus.req_i        = 8'($urandom);
        bus.req_z        = 8'($urandom);
        bus.req_k        = 8'($urandom);
        bus.req_l        = 8'($urandom);
        bus.req_d_i      = 8'($urandom);
        bus.req_read_i   = 2'($urandom);
        check("req_ready_busy", bus.req_ready, 0);

        j = 0;
        while (!bus.out_valid && j < 12) begin
            if (bus.mem_en) got_rd.push_back(bus.mem_addr);
            else check("mem_addr_idle", bus.mem_addr, 0);
            @(posedge clk);
            #1;
            j++;
        end
        check("latency", j, e_lat);
        check("read_count", got_rd.size(), exp_rd.size());
        for (int n = 0; n < exp_rd.size() && n < got_rd.size(); n++) begin
            check("read_addr", got_rd[n], exp_rd[n]);
        end
        check_bundle(pos, i, z, k, l, d, s, e_d1, e_d2, e_c);

        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_bundle(pos, i, z, k, l, d, s, e_d1, e_d2, e_c);
            check("hold_mem_en",    bus.mem_en,    0);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_hs_valid", bus.out_valid, 0);
        check("post_hs_ready", bus.req_ready, 1);
    endtask

    typedef struct {
        logic [4:0] pos;
        logic [7:0] i, z, k, l, d;
        logic [1:0] s;
        logic [7:0] d1, d2, c;
        int         lat;
        int         hold;
        logic       early;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{5'd1,  8'h11, 8'h22, 8'h05, 8'h09, 8'h33, 2'd2, 8'h04, 8'h09, 8'hFE, 4, 0,  1'b0};
        tbl[1] = '{5'd2,  8'h44, 8'h55, 8'h00, 8'h03, 8'h66, 2'd1, 8'h00, 8'h03, 8'hFD, 3, 10, 1'b0};
        tbl[2] = '{5'd3,  8'h77, 8'h88, 8'hFF, 8'hFF, 8'h99, 2'd3, 8'hFE, 8'hFF, 8'hFF, 4, 0,  1'b1};
        tbl[3] = '{5'd4,  8'hAA, 8'hBB, 8'h01, 8'h00, 8'hCC, 2'd0, 8'h00, 8'h00, 8'hFC, 4, 2,  1'b1};
        tbl[4] = '{5'd31, 8'hDD, 8'hEE, 8'h02, 8'h07, 8'hF0, 2'd3, 8'h01, 8'h07, 8'hFF, 4, 0,  1'b0};

        for (int n = 0; n < 4; n++) begin
            cvalid[n] = 1'b0;
            cval[n]   = 8'h00;
        end
        bus.req_valid    = 1'b0;
        bus.req_position = '0;
        bus.req_i        = '0;
        bus.req_z        = '0;
        bus.req_k        = '0;
        bus.req_l        = '0;
        bus.req_d_i      = '0;
        bus.req_read_i   = '0;
        bus.out_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready,  1);
        check("rst_out_valid", bus.out_valid,  0);
        check("rst_mem_en",    bus.mem_en,     0);
        check("rst_mem_addr",  bus.mem_addr,   0);
        check("rst_data_1",    bus.data_1_out, 0);
        check("rst_C",         bus.C_out,      0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 5; n++) begin
            run_req(tbl[n].pos, tbl[n].i, tbl[n].z, tbl[n].k, tbl[n].l, tbl[n].d, tbl[n].s,
                    1'b1, tbl[n].d1, tbl[n].d2, tbl[n].c, tbl[n].lat, tbl[n].hold, tbl[n].early);
        end

        // out_ready while nothing is valid must not disturb the idle stage
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready_valid", bus.out_valid, 0);
        check("idle_ready_rdy",   bus.req_ready, 1);
        bus.out_ready = 1'b0;

        // reset while in RD2: everything clears at once and nothing is presented
        bus.req_valid  = 1'b1;
        bus.req_k      = 8'h05;
        bus.req_l      = 8'h09;
        bus.req_read_i = 2'd2;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", bus.req_ready,    1);
        check("midrst_out_valid", bus.out_valid,    0);
        check("midrst_mem_en",    bus.mem_en,       0);
        check("midrst_mem_addr",  bus.mem_addr,     0);
        check("midrst_addr_out",  bus.addr_out,     0);
        check("midrst_k_out",     bus.k_out,        0);
        check("midrst_data_1",    bus.data_1_out,   0);
        for (int n = 0; n < 4; n++) cvalid[n] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            check("midrst_no_bundle", bus.out_valid, 0);
        end
        run_req(5'd9, 8'h01, 8'h02, 8'h05, 8'h09, 8'h03, 2'd2,
                1'b1, 8'h04, 8'h09, 8'hFE, 4, 1, 1'b0);

        // randomized requests against the model
        for (int n = 0; n < 40; n++) begin
            mem_xor = 8'($urandom);
            run_req(5'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    8'($urandom), 8'($urandom), 2'($urandom),
                    1'b0, 8'h00, 8'h00, 8'h00, 0,
                    $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
